encoder_rr_4_2: RTL and testbench

//   Sequential counterpart of the 2-to-4 line decoder: converts N request lines back into

---
 rtl/encoder_rr_4_2.sv | 104 ++++++++++
 tb/tb_encoder_rr_4_2.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/encoder_rr_4_2.sv
// Round-robin request encoder: sticky-captures request lines into a pending mask and emits
// their binary indices one per accepted transfer over a valid/ready handshake.
module encoder_rr_4_2 #(
  parameter int unsigned N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
  input  logic                 e_i,
  input  logic                 ready_i,
  output logic [$clog2(N)-1:0] y_o,
  output logic                 valid_o,
  output logic [N-1:0]         pend_o,
  output logic                 any_o
);

  localparam int unsigned IdxW = $clog2(N);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e            state_q;
  logic [N-1:0]      pend_q, pend_d;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   y_q;
  logic              valid_q;

  logic              acc;
  logic [N-1:0]      y_onehot;
  logic [N-1:0]      clr;
  logic [N-1:0]      rest;
  logic [IdxW-1:0]   ptr_inc;
  logic [IdxW-1:0]   sel_idle;
  logic [IdxW-1:0]   sel_rest;

  // First set bit of m at or above p, wrapping; N is a power of two so IdxW-bit adds wrap.
  function automatic logic [IdxW-1:0] rr_sel(input logic [N-1:0] m, input logic [IdxW-1:0] p);
    logic [IdxW-1:0] idx;
    logic            found;
    rr_sel = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = p + IdxW'(i);
      if (!found && m[idx]) begin
        rr_sel = idx;
        found  = 1'b1;
      end
    end
  endfunction

  always_comb begin
    acc      = valid_q & ready_i;
    y_onehot = '0;
    y_onehot[y_q] = 1'b1;
    clr      = acc ? y_onehot : '0;
    // Set wins over clear: a re-requested bit survives its own accept.
    pend_d   = (pend_q & ~clr) | (e_i ? req_i : '0);
    rest     = pend_q & ~y_onehot;
    ptr_inc  = y_q + IdxW'(1);
    sel_idle = rr_sel(pend_q, ptr_q);
    sel_rest = rr_sel(rest, ptr_inc);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pend_q  <= '0;
      ptr_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      unique case (state_q)
        StIdle: begin
          if (pend_q != '0) begin
            y_q     <= sel_idle;
            valid_q <= 1'b1;
            state_q <= StPresent;
          end
        end
        StPresent: begin
          if (ready_i) begin
            ptr_q <= ptr_inc;
            if (rest != '0) begin
              y_q <= sel_rest;
            end else begin
              valid_q <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign y_o     = y_q;
  assign valid_o = valid_q;
  assign pend_o  = pend_q;
  assign any_o   = |pend_q;

endmodule

// File: tb/tb_encoder_rr_4_2.sv
// Directed bench for encoder_rr_4_2: hand-computed vectors for reset, round-robin order,
// back-pressure, pointer wrap, set-wins re-request, capture enable and mid-flight reset.
module tb_encoder_rr_4_2;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       e;
  logic       ready;
  logic [1:0] y;
  logic       valid;
  logic [3:0] pend;
  logic       any;

  int errors = 0;
  int checks = 0;

  encoder_rr_4_2 #(.N(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .e_i     (e),
    .ready_i (ready),
    .y_o     (y),
    .valid_o (valid),
    .pend_o  (pend),
    .any_o   (any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'hF; e = 1'b1; ready = 1'b0;
    #1;
    // Test 1: reset held two cycles with requests asserted.
    step(); step();
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_y",     32'(y),     32'h0);
    chk("rst_pend",  32'(pend),  32'h0);
    chk("rst_any",   32'(any),   32'h0);

    // Test 2: single request, valid for exactly one cycle two edges later.
    rst = 1'b0; req = 4'b0100; ready = 1'b1;
    step();
    chk("t2_pend1",  32'(pend),  32'h4);
    chk("t2_valid1", 32'(valid), 32'h0);
    chk("t2_any1",   32'(any),   32'h1);
    req = 4'b0000;
    step();
    chk("t2_valid2", 32'(valid), 32'h1);
    chk("t2_y2",     32'(y),     32'h2);
    step();
    chk("t2_valid3", 32'(valid), 32'h0);
    chk("t2_pend3",  32'(pend),  32'h0);
    chk("t2_any3",   32'(any),   32'h0);

    // Test 5a: ptr=3 after serving 2; 1001 -> 3 then wrap to 0.
    req = 4'b1001;
    step();
    req = 4'b0000;
    step();
    chk("t5_y3",     32'(y),     32'h3);
    chk("t5_v3",     32'(valid), 32'h1);
    step();
    chk("t5_y0",     32'(y),     32'h0);
    chk("t5_v0",     32'(valid), 32'h1);
    step();
    chk("t5_idle",   32'(valid), 32'h0);

    // Test 5b: ptr=1; serve 3 while req[3] held -> 0 before 3 again.
    req = 4'b1001;
    step();
    req = 4'b1000;
    step();
    chk("t5b_y3",    32'(y),     32'h3);
    step();
    chk("t5b_y0",    32'(y),     32'h0);
    chk("t5b_pend",  32'(pend),  32'h9);
    req = 4'b0000;
    step();
    chk("t5b_y3again", 32'(y),   32'h3);
    chk("t5b_v",     32'(valid), 32'h1);
    step();
    chk("t5b_idle",  32'(valid), 32'h0);
    chk("t5b_pend0", 32'(pend),  32'h0);

    // Test 3: ptr=0, multi-hot 1011 drains 0,1,3 back to back.
    req = 4'b1011;
    step();
    req = 4'b0000;
    step();
    chk("t3_y0", 32'(y), 32'h0);
    step();
    chk("t3_y1", 32'(y), 32'h1);
    chk("t3_v1", 32'(valid), 32'h1);
    step();
    chk("t3_y3", 32'(y), 32'h3);
    chk("t3_v3", 32'(valid), 32'h1);
    step();
    chk("t3_idle", 32'(valid), 32'h0);

    // Test 4: back-pressure holds y=1 for five cycles, then 1 and 2 drain.
    req = 4'b0110; ready = 1'b0;
    step();
    req = 4'b0000;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_y", 32'(y),     32'h1);
      chk("t4_hold_v", 32'(valid), 32'h1);
      e = (i != 2);
      req = (i == 2) ? 4'b1000 : 4'b0000;
      step();
    end
    e = 1'b1; req = 4'b0000;
    chk("t4_pend_held", 32'(pend), 32'h6);
    ready = 1'b1;
    step();
    chk("t4_y2", 32'(y), 32'h2);
    chk("t4_v2", 32'(valid), 32'h1);
    step();
    chk("t4_idle", 32'(valid), 32'h0);
    chk("t4_pend0", 32'(pend), 32'h0);

    // Test 6a: E=0 ignores requests.
    e = 1'b0; req = 4'hF;
    step(); step(); step();
    chk("t6_pend", 32'(pend), 32'h0);
    chk("t6_valid", 32'(valid), 32'h0);

    // Test 6b: reset while presenting drops the index.
    e = 1'b1; req = 4'b0111;
    step();
    req = 4'b0000; ready = 1'b0;
    step();
    chk("t6_pre_v", 32'(valid), 32'h1);
    chk("t6_pre_y", 32'(y), 32'h0);
    rst = 1'b1; req = 4'hF;
    step();
    chk("t6_rst_v", 32'(valid), 32'h0);
    chk("t6_rst_pend", 32'(pend), 32'h0);
    chk("t6_rst_y", 32'(y), 32'h0);
    rst = 1'b0; req = 4'b0000;
    step();
    chk("t6_post_pend", 32'(pend), 32'h0);
    chk("t6_post_v", 32'(valid), 32'h0);

    // Pointer cleared by reset: 1010 must start at 1, not 3.
    req = 4'b1010; ready = 1'b1;
    step();
    req = 4'b0000;
    step();
    chk("ptr_rst_y1", 32'(y), 32'h1);
    step();
    chk("ptr_rst_y3", 32'(y), 32'h3);
    step();
    chk("ptr_rst_idle", 32'(valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
